// File: rtl/xgmii_tx_sequencer_pkg.sv
// Shared XGMII character constants, framing words and transmit sequencer states.
// Used by the sequencer, the 64B/66B encoder and the receive-side decoder.
package xgmii_tx_sequencer_pkg;

  localparam logic [7:0] XGMII_IDLE     = 8'h07;
  localparam logic [7:0] XGMII_START    = 8'hFB;
  localparam logic [7:0] XGMII_TERM     = 8'hFD;
  localparam logic [7:0] XGMII_ERROR    = 8'hFE;
  localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
  localparam logic [7:0] XGMII_SFD      = 8'hD5;

  // Lane 0 is the least significant byte and goes on the wire first.
  localparam logic [31:0] IDLE_WORD  = {4{XGMII_IDLE}};
  localparam logic [31:0] START_WORD = {{3{XGMII_PREAMBLE}}, XGMII_START};
  localparam logic [31:0] SFD_WORD   = {XGMII_SFD, {3{XGMII_PREAMBLE}}};
  localparam logic [31:0] TERM0_WORD = {{3{XGMII_IDLE}}, XGMII_TERM};
  localparam logic [31:0] ERROR_WORD = {4{XGMII_ERROR}};

  localparam logic [3:0] CTRL_ALL   = 4'b1111;
  localparam logic [3:0] CTRL_NONE  = 4'b0000;
  localparam logic [3:0] CTRL_START = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SFD,
    ST_DATA,
    ST_TERM,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/xgmii_term_formatter.sv
// Builds the Terminate-bearing word for a final word with 1..3 valid bytes.
// gap_bytes is the number of idle-gap bytes that word already carries (T included).
module xgmii_term_formatter
  import xgmii_tx_sequencer_pkg::*;
(
  input  logic [31:0] s_data,
  input  logic [3:0]  s_keep,
  output logic [31:0] data,
  output logic [3:0]  ctrl,
  output logic [4:0]  gap_bytes,
  output logic        legal
);

  always_comb begin
    data      = IDLE_WORD;
    ctrl      = ~s_keep;
    gap_bytes = 5'd0;
    legal     = 1'b1;
    case (s_keep)
      4'b0001: begin
        data      = {XGMII_IDLE, XGMII_IDLE, XGMII_TERM, s_data[7:0]};
        gap_bytes = 5'd3;
      end
      4'b0011: begin
        data      = {XGMII_IDLE, XGMII_TERM, s_data[15:0]};
        gap_bytes = 5'd2;
      end
      4'b0111: begin
        data      = {XGMII_TERM, s_data[23:0]};
        gap_bytes = 5'd1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/xgmii_tx_sequencer.sv
// Turns a byte-keyed MAC frame stream into XGMII words: Start/preamble/SFD,
// payload, Terminate placement, minimum inter-frame gap and underrun abort.
module xgmii_tx_sequencer
  import xgmii_tx_sequencer_pkg::*;
#(
  parameter int IFG_BYTES        = 12,
  parameter int XGMII_DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [XGMII_DATA_WIDTH-1:0] s_data,
  input  logic [3:0]                  s_keep,
  input  logic                        s_last,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [XGMII_DATA_WIDTH-1:0] xgmii_data_out,
  output logic [3:0]                  xgmii_ctrl_out,
  input  logic                        xgmii_ready_in,
  output logic                        underrun,
  output logic                        frame_done
);

  localparam logic [4:0] IFG_THRESH = 5'(IFG_BYTES);

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [4:0]  ifg_q, ifg_d, ifg_sat;
  logic        drain_q, drain_d;
  logic        underrun_q, underrun_d;
  logic        done_q, done_d;

  logic [31:0] fmt_data;
  logic [3:0]  fmt_ctrl;
  logic [4:0]  fmt_gap;
  logic        fmt_legal;

  xgmii_term_formatter u_term_formatter (
    .s_data    (s_data),
    .s_keep    (s_keep),
    .data      (fmt_data),
    .ctrl      (fmt_ctrl),
    .gap_bytes (fmt_gap),
    .legal     (fmt_legal)
  );

  // ifg_q counts gap bytes already loaded; a Start may be loaded once it reaches the minimum.
  assign ifg_sat = (ifg_q > 5'd27) ? 5'd31 : ifg_q + 5'd4;

  // Handshake: an input word transfers in a cycle where s_valid && s_ready;
  // an output word transfers in a cycle where xgmii_ready_in is high, and the
  // output register loads its successor in that same cycle.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    ctrl_d     = ctrl_q;
    ifg_d      = ifg_q;
    drain_d    = drain_q;
    underrun_d = 1'b0;
    done_d     = 1'b0;
    s_ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xgmii_ready_in) begin
          if (s_valid && (ifg_q >= IFG_THRESH)) begin
            data_d  = START_WORD;
            ctrl_d  = CTRL_START;
            state_d = ST_SFD;
          end else begin
            data_d = IDLE_WORD;
            ctrl_d = CTRL_ALL;
            ifg_d  = ifg_sat;
          end
        end
      end
      ST_SFD: begin
        if (xgmii_ready_in) begin
          data_d  = SFD_WORD;
          ctrl_d  = CTRL_NONE;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        s_ready = xgmii_ready_in && s_valid;
        if (xgmii_ready_in) begin
          if (!s_valid) begin
            data_d     = ERROR_WORD;
            ctrl_d     = CTRL_ALL;
            underrun_d = 1'b1;
            drain_d    = 1'b1;
            state_d    = ST_TERM;
          end else if (!s_last) begin
            data_d = s_data;
            ctrl_d = CTRL_NONE;
          end else if (s_keep == 4'b1111) begin
            data_d  = s_data;
            ctrl_d  = CTRL_NONE;
            drain_d = 1'b0;
            state_d = ST_TERM;
          end else if (fmt_legal) begin
            data_d  = fmt_data;
            ctrl_d  = fmt_ctrl;
            ifg_d   = fmt_gap;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            data_d     = ERROR_WORD;
            ctrl_d     = CTRL_ALL;
            underrun_d = 1'b1;
            drain_d    = 1'b0;
            state_d    = ST_TERM;
          end
        end
      end
      ST_TERM: begin
        if (xgmii_ready_in) begin
          data_d  = TERM0_WORD;
          ctrl_d  = CTRL_ALL;
          ifg_d   = 5'd4;
          done_d  = 1'b1;
          state_d = drain_q ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // The rest of an aborted frame is swallowed at full rate, even under encoder stall.
        s_ready = 1'b1;
        if (xgmii_ready_in) begin
          data_d = IDLE_WORD;
          ctrl_d = CTRL_ALL;
          ifg_d  = ifg_sat;
        end
        if (s_valid && s_last) begin
          drain_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      data_q     <= IDLE_WORD;
      ctrl_q     <= CTRL_ALL;
      ifg_q      <= 5'd31;
      drain_q    <= 1'b0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
      ifg_q      <= ifg_d;
      drain_q    <= drain_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
    end
  end

  assign xgmii_data_out = data_q;
  assign xgmii_ctrl_out = ctrl_q;
  assign underrun       = underrun_q;
  assign frame_done     = done_q;

endmodule
